// File: rtl/inv_shiftrows_serial.sv
// Byte-serial AES InvShiftRows: loads 16 state bytes, then emits them row-unshifted.
// Optional define INV_SHIFTROWS_BYPASS_EN adds a bypass input sampled with byte 0.
module inv_shiftrows_serial (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_byte,
   output logic       in_ready,
   output logic       out_valid,
   output logic [7:0] out_byte,
   output logic       out_last,
   input  logic       out_ready,
   input  logic       abort,
`ifdef INV_SHIFTROWS_BYPASS_EN
   input  logic       bypass,
`endif
   output logic       busy
);

   typedef enum logic [0:0] {StLoad, StUnload} state_e;

   state_e     state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [7:0] mem_q [16];
   logic       in_xfer, out_xfer;
   logic [1:0] src_col;
   logic [3:0] src_idx;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   // Index is {column, row}; output (r,c) reads input (r,(c-r) mod 4).
   assign src_col = idx_q[3:2] - idx_q[1:0];

`ifdef INV_SHIFTROWS_BYPASS_EN
   logic bypass_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bypass_q <= 1'b0;
      end else if (in_xfer && !abort && idx_q == 4'd0) begin
         bypass_q <= bypass;
      end
   end

   assign src_idx = bypass_q ? idx_q : {src_col, idx_q[1:0]};
`else
   assign src_idx = {src_col, idx_q[1:0]};
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StLoad;
         idx_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Buffer write; an aborting cycle never stores its byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 16; k++) begin
            mem_q[k] <= 8'h00;
         end
      end else if (in_xfer && !abort) begin
         mem_q[idx_q] <= in_byte;
      end
   end

   // Next-state logic; the 4-bit index wraps to 0 exactly on the state change
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (abort) begin
         state_d = StLoad;
         idx_d   = 4'd0;
      end else begin
         unique case (state_q)
            StLoad: begin
               if (in_xfer) begin
                  idx_d = idx_q + 4'd1;
                  if (idx_q == 4'd15) begin
                     state_d = StUnload;
                  end
               end
            end
            StUnload: begin
               if (out_xfer) begin
                  idx_d = idx_q + 4'd1;
                  if (idx_q == 4'd15) begin
                     state_d = StLoad;
                  end
               end
            end
            default: begin
               state_d = StLoad;
               idx_d   = 4'd0;
            end
         endcase
      end
   end

   // Outputs
   always_comb begin
      in_ready  = (state_q == StLoad);
      out_valid = (state_q == StUnload);
      out_last  = out_valid && (idx_q == 4'd15);
      busy      = out_valid || (idx_q != 4'd0);
      out_byte  = out_valid ? mem_q[src_idx] : 8'h00;
   end

endmodule

// File: tb/tb_inv_shiftrows_serial.sv
// Self-checking bench for inv_shiftrows_serial: directed scenarios plus random blocks
// checked against an index-arithmetic InvShiftRows model.
module tb_inv_shiftrows_serial;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_byte;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_byte;
   logic       out_last;
   logic       out_ready;
   logic       abort;
   logic       busy;
   logic       bypass;

   int checks = 0;
   int errors = 0;

   logic [7:0] blk_in  [16];
   logic [7:0] ref_out [16];

   inv_shiftrows_serial dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_byte   (in_byte),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_byte  (out_byte),
      .out_last  (out_last),
      .out_ready (out_ready),
      .abort     (abort),
`ifdef INV_SHIFTROWS_BYPASS_EN
      .bypass    (bypass),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   // Model: output (r,c) takes input (r,(c-r) mod 4); bypass gives identity.
   task automatic compute_ref(input logic bp);
      for (int i = 0; i < 16; i++) begin
         int r, c, src;
         r   = i % 4;
         c   = i / 4;
         src = 4 * ((c - r + 4) % 4) + r;
         ref_out[i] = bp ? blk_in[i] : blk_in[4'(src)];
      end
   endtask

   task automatic fill_seq();
      for (int i = 0; i < 16; i++) blk_in[i] = 8'(i);
   endtask

   task automatic ref_029();
      ref_out = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                  8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
   endtask

   // Entered and left at a negedge.
   task automatic load_block(input int unsigned gap_pct, input logic bp, input int nbytes);
      int i = 0;
      int guard = 0;
      while (i < nbytes && guard < 2000) begin
         chk1("load_in_ready", in_ready, 1'b1);
         chk1("load_out_valid", out_valid, 1'b0);
         in_valid  = ($urandom_range(99) >= gap_pct);
         in_byte   = in_valid ? blk_in[i] : 8'($urandom);
         out_ready = 1'($urandom_range(1));
         bypass    = (i == 0) ? bp : 1'($urandom_range(1));
         @(posedge clk);
         if (in_valid) i++;
         guard++;
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      if (i < nbytes) chk1("load_timeout", 1'b0, 1'b1);
      if (nbytes == 16) chk1("first_out_latency", out_valid, 1'b1);
   endtask

   // mode 0: always ready, 1: toggle starting low, 2: random
   task automatic unload_block(input int mode, input int nbytes);
      int j = 0;
      int guard = 0;
      while (j < nbytes && guard < 2000) begin
         chk1("unload_out_valid", out_valid, 1'b1);
         chk1("unload_in_ready", in_ready, 1'b0);
         chk1("unload_busy", busy, 1'b1);
         chk8($sformatf("out_byte[%0d]", j), out_byte, ref_out[j]);
         chk1($sformatf("out_last[%0d]", j), out_last, j == 15);
         out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? guard[0] : 1'($urandom_range(1));
         in_valid  = 1'($urandom_range(1));
         in_byte   = 8'($urandom);
         @(posedge clk);
         if (out_ready) j++;
         guard++;
         @(negedge clk);
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      if (j < nbytes) chk1("unload_timeout", 1'b0, 1'b1);
      if (nbytes == 16) begin
         chk1("done_in_ready", in_ready, 1'b1);
         chk1("done_out_valid", out_valid, 1'b0);
         chk1("done_busy", busy, 1'b0);
      end
   endtask

   initial begin
      clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
      out_ready = 1'b0; abort = 1'b0; bypass = 1'b0;
      repeat (2) @(negedge clk);
      // Traffic during reset must not be recorded
      in_valid = 1'b1; in_byte = 8'h5A; out_ready = 1'b1;
      @(negedge clk);
      chk1("rst_in_ready", in_ready, 1'b1);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_out_last", out_last, 1'b0);
      chk8("rst_out_byte", out_byte, 8'h00);
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk1("post_rst_busy", busy, 1'b0);

      // Sequential block, always ready
      fill_seq(); ref_029();
      load_block(0, 1'b0, 16);
      unload_block(0, 16);

      // Same block, out_ready toggling
      load_block(0, 1'b0, 16);
      unload_block(1, 16);

      // Abort mid-load with a simultaneous input byte
      load_block(0, 1'b0, 7);
      chk1("pre_abort_busy", busy, 1'b1);
      in_valid = 1'b1; in_byte = 8'hAA; abort = 1'b1;
      @(posedge clk); @(negedge clk);
      abort = 1'b0; in_valid = 1'b0;
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_in_ready", in_ready, 1'b1);
      load_block(0, 1'b0, 16);
      unload_block(0, 16);

      // Abort mid-unload with a simultaneous output transfer
      load_block(20, 1'b0, 16);
      unload_block(2, 5);
      out_ready = 1'b1; abort = 1'b1;
      @(posedge clk); @(negedge clk);
      abort = 1'b0; out_ready = 1'b0;
      chk1("abort_unl_out_valid", out_valid, 1'b0);
      chk1("abort_unl_busy", busy, 1'b0);
      load_block(0, 1'b0, 16);
      unload_block(0, 16);

      // Reset after 10 output bytes
      load_block(0, 1'b0, 16);
      unload_block(0, 10);
      rst_n = 1'b0;
      #1;
      chk1("midrst_out_valid", out_valid, 1'b0);
      chk1("midrst_in_ready", in_ready, 1'b1);
      chk1("midrst_busy", busy, 1'b0);
      chk8("midrst_out_byte", out_byte, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 16; i++) blk_in[i] = 8'($urandom);
      compute_ref(1'b0);
      load_block(10, 1'b0, 16);
      unload_block(2, 16);

      // Round trip from forward ShiftRows output
      blk_in = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                 8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
      for (int i = 0; i < 16; i++) ref_out[i] = 8'(i);
      load_block(0, 1'b0, 16);
      unload_block(0, 16);

`ifdef INV_SHIFTROWS_BYPASS_EN
      fill_seq();
      for (int i = 0; i < 16; i++) ref_out[i] = 8'(i);
      load_block(0, 1'b1, 16);
      unload_block(0, 16);
      ref_029();
      load_block(0, 1'b0, 16);
      unload_block(0, 16);
`endif

      // Random blocks with random gaps and stalls
      for (int n = 0; n < 8; n++) begin
         logic bp;
`ifdef INV_SHIFTROWS_BYPASS_EN
         bp = 1'($urandom_range(1));
`else
         bp = 1'b0;
`endif
         for (int i = 0; i < 16; i++) blk_in[i] = 8'($urandom);
         compute_ref(bp);
         load_block(25, bp, 16);
         unload_block(2, 16);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
